// File: rtl/register_array_kv_pkg.sv
// Shared types for the sorted key/value register-array priority queue.
package register_array_kv_pkg;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_ENQ,
    OP_DEQ,
    OP_REPLACE,
    OP_FLUSH
  } op_e;

  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_NEW,
    SEL_UPPER,
    SEL_LOWER
  } slot_sel_e;

  localparam int STATS_W = 32;

endpackage

// File: rtl/register_array_kv_cell.sv
// One queue slot: key/value registers plus the hold/new/upper/lower select.
module register_array_kv_cell
  import register_array_kv_pkg::*;
#(
  parameter int KW      = 16,
  parameter int VW      = 8,
  parameter int IS_HEAD = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  op_e           op_i,
  input  logic          ins_self_i,
  input  logic          ins_upper_i,
  input  logic          ins_lower_i,
  input  logic [KW-1:0] new_key_i,
  input  logic [VW-1:0] new_val_i,
  input  logic [KW-1:0] upper_key_i,
  input  logic [VW-1:0] upper_val_i,
  input  logic [KW-1:0] lower_key_i,
  input  logic [VW-1:0] lower_val_i,
  output logic [KW-1:0] key_o,
  output logic [VW-1:0] val_o
);

  slot_sel_e     sel;
  logic [KW-1:0] key_d, key_q;
  logic [VW-1:0] val_d, val_q;

  // ins_* flags mean "the new entry lands at or above that slot".
  // On replace the surviving entries shift up by one, so a slot whose own
  // flag is already set keeps its contents (shift up then back down).
  always_comb begin
    sel = SEL_HOLD;
    case (op_i)
      OP_ENQ: begin
        if (ins_upper_i)     sel = SEL_UPPER;
        else if (ins_self_i) sel = SEL_NEW;
      end
      OP_REPLACE: begin
        if (IS_HEAD == 0 && ins_self_i) sel = SEL_HOLD;
        else if (ins_lower_i)           sel = SEL_NEW;
        else                            sel = SEL_LOWER;
      end
      OP_DEQ:  sel = SEL_LOWER;
      default: sel = SEL_HOLD;
    endcase
  end

  always_comb begin
    key_d = key_q;
    val_d = val_q;
    if (op_i == OP_FLUSH) begin
      key_d = '0;
      val_d = '0;
    end else begin
      case (sel)
        SEL_NEW:   begin key_d = new_key_i;   val_d = new_val_i;   end
        SEL_UPPER: begin key_d = upper_key_i; val_d = upper_val_i; end
        SEL_LOWER: begin key_d = lower_key_i; val_d = lower_val_i; end
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_q <= '0;
      val_q <= '0;
    end else begin
      key_q <= key_d;
      val_q <= val_d;
    end
  end

  assign key_o = key_q;
  assign val_o = val_q;

endmodule

// File: rtl/register_array_kv.sv
// Sorted (key, value) priority queue; head always at slot 0, one op per cycle.
// Optional saturating statistics counters under REGISTER_ARRAY_KV_STATS_EN.
module register_array_kv
  import register_array_kv_pkg::*;
#(
  parameter int QUEUE_SIZE     = 256,
  parameter int KEY_WIDTH      = 16,
  parameter int VAL_WIDTH      = 8,
  parameter int MIN_FIRST      = 0,
  parameter int ENQ_ENA        = 1,
  parameter int OVERFLOW_EVICT = 0,
  localparam int CW            = $clog2(QUEUE_SIZE + 1)
) (
  input  logic                 i_CLK,
  input  logic                 i_RSTn,
  input  logic                 i_wrt,
  input  logic                 i_read,
  input  logic                 i_flush,
  input  logic [KEY_WIDTH-1:0] i_key,
  input  logic [VAL_WIDTH-1:0] i_val,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [CW-1:0]        o_count,
  output logic [KEY_WIDTH-1:0] o_key,
  output logic [VAL_WIDTH-1:0] o_val,
`ifdef REGISTER_ARRAY_KV_STATS_EN
  output logic [STATS_W-1:0]   o_enq_cnt,
  output logic [STATS_W-1:0]   o_deq_cnt,
  output logic [STATS_W-1:0]   o_drop_cnt,
`endif
  output logic                 o_drop
);

  logic [QUEUE_SIZE-1:0][KEY_WIDTH-1:0] key_q, up_key, lo_key;
  logic [QUEUE_SIZE-1:0][VAL_WIDTH-1:0] val_q, up_val, lo_val;
  logic [QUEUE_SIZE:0]                  ins;
  logic [QUEUE_SIZE-1:0]                ins_up, ins_lo;
  logic [CW-1:0]                        count_d, count_q;
  logic                                 drop_d, drop_q;
  logic                                 full, empty;
  op_e                                  op;

  assign full  = (count_q == CW'(QUEUE_SIZE));
  assign empty = (count_q == '0);

  // Unoccupied slots always accept the new entry; ties never outrank, so
  // equal keys keep arrival order.
  for (genvar g = 0; g < QUEUE_SIZE; g++) begin : g_cmp
    logic vld;
    assign vld    = CW'(g) < count_q;
    assign ins[g] = !vld || ((MIN_FIRST != 0) ? (i_key < key_q[g]) : (i_key > key_q[g]));
  end
  assign ins[QUEUE_SIZE] = 1'b1;

  assign ins_up = {ins[QUEUE_SIZE-2:0], 1'b0};
  assign ins_lo = ins[QUEUE_SIZE:1];
  assign up_key = key_q << KEY_WIDTH;
  assign up_val = val_q << VAL_WIDTH;
  assign lo_key = key_q >> KEY_WIDTH;
  assign lo_val = val_q >> VAL_WIDTH;

  always_comb begin
    op      = OP_NONE;
    drop_d  = 1'b0;
    count_d = count_q;
    if (i_flush) begin
      op      = OP_FLUSH;
      count_d = '0;
    end else if (i_wrt && i_read && !empty) begin
      op = OP_REPLACE;
    end else if (i_wrt) begin
      // an empty-queue replace falls through here and is always accepted
      if (ENQ_ENA == 0 && !i_read) begin
        drop_d = 1'b1;
      end else if (!full) begin
        op      = OP_ENQ;
        count_d = count_q + 1'b1;
      end else if (OVERFLOW_EVICT != 0 && ins[QUEUE_SIZE-1]) begin
        op     = OP_ENQ;
        drop_d = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end else if (i_read) begin
      if (empty) begin
        drop_d = 1'b1;
      end else begin
        op      = OP_DEQ;
        count_d = count_q - 1'b1;
      end
    end
  end

  for (genvar g = 0; g < QUEUE_SIZE; g++) begin : g_slot
    register_array_kv_cell #(
      .KW     (KEY_WIDTH),
      .VW     (VAL_WIDTH),
      .IS_HEAD((g == 0) ? 1 : 0)
    ) u_cell (
      .clk_i      (i_CLK),
      .rst_ni     (i_RSTn),
      .op_i       (op),
      .ins_self_i (ins[g]),
      .ins_upper_i(ins_up[g]),
      .ins_lower_i(ins_lo[g]),
      .new_key_i  (i_key),
      .new_val_i  (i_val),
      .upper_key_i(up_key[g]),
      .upper_val_i(up_val[g]),
      .lower_key_i(lo_key[g]),
      .lower_val_i(lo_val[g]),
      .key_o      (key_q[g]),
      .val_o      (val_q[g])
    );
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

`ifdef REGISTER_ARRAY_KV_STATS_EN
  logic [STATS_W-1:0] enq_cnt_q, deq_cnt_q, drop_cnt_q;
  logic               enq_acc, deq_acc;

  assign enq_acc = (op == OP_ENQ) || (op == OP_REPLACE);
  assign deq_acc = (op == OP_DEQ) || (op == OP_REPLACE);

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      enq_cnt_q  <= '0;
      deq_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (enq_acc && enq_cnt_q != '1)  enq_cnt_q  <= enq_cnt_q + 1'b1;
      if (deq_acc && deq_cnt_q != '1)  deq_cnt_q  <= deq_cnt_q + 1'b1;
      if (drop_d && drop_cnt_q != '1)  drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign o_enq_cnt  = enq_cnt_q;
  assign o_deq_cnt  = deq_cnt_q;
  assign o_drop_cnt = drop_cnt_q;
`endif

  assign o_full  = full;
  assign o_empty = empty;
  assign o_count = count_q;
  assign o_key   = key_q[0];
  assign o_val   = val_q[0];
  assign o_drop  = drop_q;

endmodule

// File: tb/tb_register_array_kv.sv
// Scoreboard bench: four small queues with different configurations share one stimulus stream.
module tb_register_array_kv;
  localparam int N  = 4;
  localparam int KW = 8;
  localparam int VW = 8;
  // dut0: max/evict, dut1: max/no-evict, dut2: min-first, dut3: min-first with enqueue disabled
  localparam bit [3:0] MINF  = 4'b1100;
  localparam bit [3:0] ENA   = 4'b0111;
  localparam bit [3:0] EVICT = 4'b0001;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          wrt = 1'b0, rd = 1'b0, fl = 1'b0;
  logic [KW-1:0] key_i = '0;
  logic [VW-1:0] val_i = '0;
  logic          full[4], empty[4], drop[4];
  logic [2:0]    cnt[4];
  logic [KW-1:0] ko[4];
  logic [VW-1:0] vo[4];
`ifdef REGISTER_ARRAY_KV_STATS_EN
  logic [31:0]   enq_c[4], deq_c[4], drp_c[4];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    register_array_kv #(
      .QUEUE_SIZE(N), .KEY_WIDTH(KW), .VAL_WIDTH(VW),
      .MIN_FIRST(int'(MINF[g])), .ENQ_ENA(int'(ENA[g])), .OVERFLOW_EVICT(int'(EVICT[g]))
    ) u_dut (
      .i_CLK(clk), .i_RSTn(rst_n), .i_wrt(wrt), .i_read(rd), .i_flush(fl),
      .i_key(key_i), .i_val(val_i),
      .o_full(full[g]), .o_empty(empty[g]), .o_count(cnt[g]),
      .o_key(ko[g]), .o_val(vo[g]),
`ifdef REGISTER_ARRAY_KV_STATS_EN
      .o_enq_cnt(enq_c[g]), .o_deq_cnt(deq_c[g]), .o_drop_cnt(drp_c[g]),
`endif
      .o_drop(drop[g])
    );
  end

  typedef struct {
    int          d;
    logic [7:0]  k;
    logic [7:0]  v;
    logic [2:0]  c;
    logic        dr;
    bit          rs;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0, fails = 0;
  event ev_chk;

  task automatic ex(input int d, input int k, input int v, input int c, input logic dr,
                    input string nm, input bit rs = 1'b0);
    exp_t e;
    e.d = d; e.k = 8'(k); e.v = 8'(v); e.c = 3'(c); e.dr = dr; e.rs = rs; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic drv(input logic w, input logic r, input logic f, input int k, input int v);
    @(negedge clk);
    wrt = w; rd = r; fl = f; key_i = 8'(k); val_i = 8'(v);
  endtask

  task automatic enq(input int k, input int v); drv(1'b1, 1'b0, 1'b0, k, v); endtask
  task automatic rep(input int k, input int v); drv(1'b1, 1'b1, 1'b0, k, v); endtask
  task automatic deq();   drv(1'b0, 1'b1, 1'b0, 0, 0); endtask
  task automatic flush(); drv(1'b0, 1'b0, 1'b1, 0, 0); endtask
  task automatic idle();  drv(1'b0, 1'b0, 1'b0, 0, 0); endtask

  // Monitor: everything queued before an edge (or an explicit check event) describes the outputs after it.
  always begin : mon
    exp_t e;
    bit   ok;
    @(posedge clk or ev_chk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      ok = (ko[e.d] === e.k) && (vo[e.d] === e.v) && (cnt[e.d] === e.c) && (drop[e.d] === e.dr) &&
           (full[e.d] === (e.c == 3'd4)) && (empty[e.d] === (e.c == 3'd0));
      if (!ok) begin
        fails++;
        $display("FAIL %s dut%0d: got key=%0d val=%0d cnt=%0d drop=%0b full=%0b empty=%0b, want key=%0d val=%0d cnt=%0d drop=%0b",
                 e.nm, e.d, ko[e.d], vo[e.d], cnt[e.d], drop[e.d], full[e.d], empty[e.d], e.k, e.v, e.c, e.dr);
      end
`ifdef REGISTER_ARRAY_KV_STATS_EN
      if (e.rs) begin
        checks++;
        if (enq_c[e.d] !== 32'd0 || deq_c[e.d] !== 32'd0 || drp_c[e.d] !== 32'd0) begin
          fails++;
          $display("FAIL %s_stats dut%0d: got enq=%0d deq=%0d drop=%0d, want all 0",
                   e.nm, e.d, enq_c[e.d], deq_c[e.d], drp_c[e.d]);
        end
      end
`endif
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle();      ex(0, 0, 0, 0, 1'b0, "reset_state", 1'b1); ex(3, 0, 0, 0, 1'b0, "reset_state3");

    // max-first ordering
    enq(5, 10);  ex(0, 5, 10, 1, 1'b0, "enq5");
    enq(9, 11);  ex(0, 9, 11, 2, 1'b0, "enq9");
    enq(1, 12);  ex(0, 9, 11, 3, 1'b0, "enq1");
    enq(7, 13);  ex(0, 9, 11, 4, 1'b0, "enq7_full");
    deq();       ex(0, 7, 13, 3, 1'b0, "deq_a");
    deq();       ex(0, 5, 10, 2, 1'b0, "deq_b");
    deq();       ex(0, 1, 12, 1, 1'b0, "deq_c");
    deq();       ex(0, 0, 0, 0, 1'b0, "deq_last");
    deq();       ex(0, 0, 0, 0, 1'b1, "deq_empty_drop");
    deq();       ex(0, 0, 0, 0, 1'b1, "drop_back_to_back");
    idle();      ex(0, 0, 0, 0, 1'b0, "drop_clear");

    // FIFO among equal keys
    enq(3, 10);  ex(0, 3, 10, 1, 1'b0, "tie_a");
    enq(3, 11);  ex(0, 3, 10, 2, 1'b0, "tie_b");
    enq(3, 12);  ex(0, 3, 10, 3, 1'b0, "tie_c");
    deq();       ex(0, 3, 11, 2, 1'b0, "tie_deq_b");
    deq();       ex(0, 3, 12, 1, 1'b0, "tie_deq_c");
    deq();       ex(0, 0, 0, 0, 1'b0, "tie_empty");

    // overflow: dut0 evicts, dut1 does not
    enq(9, 1);   ex(0, 9, 1, 1, 1'b0, "fill9");
    enq(7, 2);   ex(0, 9, 1, 2, 1'b0, "fill7");
    enq(5, 3);   ex(0, 9, 1, 3, 1'b0, "fill5");
    enq(1, 4);   ex(0, 9, 1, 4, 1'b0, "fill1");  ex(1, 9, 1, 4, 1'b0, "fill1_ne");
    enq(6, 6);   ex(0, 9, 1, 4, 1'b1, "evict6"); ex(1, 9, 1, 4, 1'b1, "noevict6");
    enq(2, 7);   ex(0, 9, 1, 4, 1'b1, "evict2_reject"); ex(1, 9, 1, 4, 1'b1, "noevict2");
    idle();      ex(0, 9, 1, 4, 1'b0, "evict_drop_clear");
    deq();       ex(0, 7, 2, 3, 1'b0, "ev_deq_a"); ex(1, 7, 2, 3, 1'b0, "ne_deq_a");
    deq();       ex(0, 6, 6, 2, 1'b0, "ev_deq_b"); ex(1, 5, 3, 2, 1'b0, "ne_deq_b");
    deq();       ex(0, 5, 3, 1, 1'b0, "ev_deq_c"); ex(1, 1, 4, 1, 1'b0, "ne_deq_c");
    deq();       ex(0, 0, 0, 0, 1'b0, "ev_deq_d"); ex(1, 0, 0, 0, 1'b0, "ne_deq_d");

    // replace
    flush();     ex(0, 0, 0, 0, 1'b0, "flush0");
    enq(9, 9);   ex(0, 9, 9, 1, 1'b0, "r_fill9");
    enq(7, 7);   ex(0, 9, 9, 2, 1'b0, "r_fill7");
    enq(5, 5);   ex(0, 9, 9, 3, 1'b0, "r_fill5");
    rep(8, 8);   ex(0, 8, 8, 3, 1'b0, "rep8");
    rep(4, 4);   ex(0, 7, 7, 3, 1'b0, "rep4");
    deq();       ex(0, 5, 5, 2, 1'b0, "rep_deq_a");
    deq();       ex(0, 4, 4, 1, 1'b0, "rep_deq_b");
    deq();       ex(0, 0, 0, 0, 1'b0, "rep_deq_c");
    rep(3, 3);   ex(0, 3, 3, 1, 1'b0, "rep_on_empty");

    // min-first (dut2) and enqueue-disabled (dut3)
    flush();     ex(2, 0, 0, 0, 1'b0, "flush2"); ex(3, 0, 0, 0, 1'b0, "flush3");
    enq(6, 6);   ex(2, 6, 6, 1, 1'b0, "min_enq6"); ex(3, 0, 0, 0, 1'b1, "ena0_drop6");
    enq(2, 2);   ex(2, 2, 2, 2, 1'b0, "min_enq2");
    enq(4, 4);   ex(2, 2, 2, 3, 1'b0, "min_enq4"); ex(3, 0, 0, 0, 1'b1, "ena0_drop4");
    rep(3, 3);   ex(2, 3, 3, 3, 1'b0, "min_rep3"); ex(3, 3, 3, 1, 1'b0, "ena0_rep_empty");
    enq(1, 1);   ex(2, 1, 1, 4, 1'b0, "min_enq1"); ex(3, 3, 3, 1, 1'b1, "ena0_enq1_drop");
    deq();       ex(2, 3, 3, 3, 1'b0, "min_deq_a"); ex(3, 0, 0, 0, 1'b0, "ena0_deq");
    deq();       ex(2, 4, 4, 2, 1'b0, "min_deq_b"); ex(3, 0, 0, 0, 1'b1, "ena0_deq_empty");
    flush();     ex(2, 0, 0, 0, 1'b0, "min_flush"); ex(3, 0, 0, 0, 1'b0, "ena0_flush");

    // async reset in the middle of a replace on a full queue
    enq(9, 1);   ex(0, 9, 1, 1, 1'b0, "rst_fill9");
    enq(7, 2);
    enq(5, 3);
    enq(1, 4);   ex(0, 9, 1, 4, 1'b0, "rst_full");
    @(negedge clk);
    wrt = 1'b1; rd = 1'b1; key_i = 8'd8; val_i = 8'd8;
    #2 rst_n = 1'b0;
    #1 ex(0, 0, 0, 0, 1'b0, "async_rst", 1'b1);
    ->ev_chk;
    @(negedge clk);
    wrt = 1'b0; rd = 1'b0;
    rst_n = 1'b1;
    idle();      ex(0, 0, 0, 0, 1'b0, "post_rst");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
